// File: rtl/bsg_mem_1rw_sync_rv_master_if.sv
// Request, response and RAM-side signal bundle for bsg_mem_1rw_sync_rv_master.
// The slave modport is the sequencer's view; the master modport is the client/RAM environment.
interface bsg_mem_1rw_sync_rv_master_if #(
    parameter int width_p = -1,
    parameter int els_p   = -1
);
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;

    logic                     v_i;
    logic                     w_i;
    logic [addr_width_lp-1:0] addr_i;
    logic [width_p-1:0]       data_i;
    logic                     ready_o;

    logic                     v_o;
    logic [width_p-1:0]       data_o;
    logic                     yumi_i;

    logic                     mem_v_o;
    logic                     mem_w_o;
    logic [addr_width_lp-1:0] mem_addr_o;
    logic [width_p-1:0]       mem_data_o;
    logic [width_p-1:0]       mem_data_i;

    modport slave (
        input  v_i, w_i, addr_i, data_i, yumi_i, mem_data_i,
        output ready_o, v_o, data_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o
    );

    modport master (
        output v_i, w_i, addr_i, data_i, yumi_i, mem_data_i,
        input  ready_o, v_o, data_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/bsg_mem_1rw_sync_rv_master.sv
// Client-side sequencer for a 1rw synchronous RAM: valid/ready requests in,
// valid/yumi read responses out through a 2-entry buffer with bypass.
module bsg_mem_1rw_sync_rv_master #(
    parameter int width_p = -1,
    parameter int els_p   = -1
) (
    input  logic clk_i,
    input  logic reset_n_i,
    bsg_mem_1rw_sync_rv_master_if.slave bus
);

    logic               inflight_q, inflight_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               wptr_q, wptr_d;
    logic               rptr_q, rptr_d;
    logic [width_p-1:0] fifo_q [2];

    logic [1:0] occ;
    logic       ready;
    logic       acc;
    logic       fifo_empty;
    logic       push;
    logic       pop;

    // Credits cover both the read in the RAM pipeline and the buffered responses.
    assign occ        = {1'b0, inflight_q} + cnt_q;
    assign ready      = reset_n_i & (occ < 2'd2);
    assign acc        = bus.v_i & ready;
    assign fifo_empty = (cnt_q == 2'd0);

    // RAM data is only valid for one cycle: keep it unless it bypasses straight out.
    assign push = inflight_q & ~(fifo_empty & bus.yumi_i);
    assign pop  = bus.yumi_i & ~fifo_empty;

    always_comb begin
        inflight_d = acc & ~bus.w_i;
        cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
        wptr_d     = wptr_q ^ push;
        rptr_d     = rptr_q ^ pop;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            inflight_q <= 1'b0;
            cnt_q      <= 2'd0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wptr_q] <= bus.mem_data_i;
    end

    assign bus.ready_o    = ready;
    assign bus.mem_v_o    = acc;
    assign bus.mem_w_o    = bus.w_i;
    assign bus.mem_addr_o = bus.addr_i;
    assign bus.mem_data_o = bus.data_i;

    assign bus.v_o    = inflight_q | ~fifo_empty;
    assign bus.data_o = fifo_empty ? bus.mem_data_i : fifo_q[rptr_q];

    a_params: assert property (@(posedge clk_i) (width_p >= 1) && (els_p >= 1))
        else $error("width_p and els_p must be set to positive values");

    a_yumi: assert property (@(posedge clk_i) disable iff (!reset_n_i) bus.yumi_i |-> bus.v_o)
        else $error("yumi_i asserted without v_o");

    a_ctrl_known: assert property (@(posedge clk_i) disable iff (!reset_n_i) !$isunknown({bus.v_i, bus.w_i}))
        else $error("v_i/w_i unknown out of reset");

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i) push |-> (cnt_q != 2'd2))
        else $error("push into full response buffer");

endmodule

// File: tb/tb_bsg_mem_1rw_sync_rv_master.sv
// Randomized and directed bench for bsg_mem_1rw_sync_rv_master with a RAM model and a response scoreboard.
module tb_bsg_mem_1rw_sync_rv_master;
    localparam int W  = 8;
    localparam int E  = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bsg_mem_1rw_sync_rv_master_if #(.width_p(W), .els_p(E)) bus ();

    bsg_mem_1rw_sync_rv_master #(.width_p(W), .els_p(E)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    // Synchronous RAM: read data appears the cycle after the read.
    logic [W-1:0] ram [E];
    always @(posedge clk) begin
        if (bus.mem_v_o) begin
            if (bus.mem_w_o) ram[bus.mem_addr_o] <= bus.mem_data_o;
            else             bus.mem_data_i      <= ram[bus.mem_addr_o];
        end
    end

    logic [W-1:0] ref_mem [E];
    logic [W-1:0] exp_q [$];
    int tests = 0;
    int fails = 0;
    int resp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: response valid must track outstanding reads; each taken response pops the scoreboard.
    always @(negedge clk) begin
        logic [W-1:0] e;
        chk("resp_valid", {31'd0, bus.v_o}, {31'd0, exp_q.size() != 0});
        if (bus.v_o === 1'b1 && bus.yumi_i === 1'b1) begin
            resp_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL resp_unexpected: got %0h expected none at %0t", bus.data_o, $time);
            end else begin
                e = exp_q.pop_front();
                chk("resp_data", {24'd0, bus.data_o}, {24'd0, e});
            end
        end
    end

    task automatic cyc(input bit v, input bit w, input logic [AW-1:0] a, input logic [W-1:0] d, input bit y);
        bit rdy_exp;
        bit acc;
        @(posedge clk); #1;
        rdy_exp = (exp_q.size() < 2);
        chk("ready", {31'd0, bus.ready_o}, {31'd0, rdy_exp});
        bus.v_i    = v;
        bus.w_i    = w;
        bus.addr_i = a;
        bus.data_i = d;
        bus.yumi_i = y & bus.v_o;
        @(negedge clk); #1;
        acc = v && rdy_exp;
        chk("mem_v", {31'd0, bus.mem_v_o}, {31'd0, acc});
        if (acc) begin
            if (w) ref_mem[a] = d;
            else   exp_q.push_back(ref_mem[a]);
        end
    endtask

    initial begin
        int r0;
        for (int i = 0; i < E; i++) begin
            ram[i]     = W'(i * 3);
            ref_mem[i] = W'(i * 3);
        end
        bus.v_i = 1'b1; bus.w_i = 1'b0; bus.addr_i = '0; bus.data_i = '0; bus.yumi_i = 1'b0;

        // Reset with a pending request on the input
        #12;
        chk("rst_ready", {31'd0, bus.ready_o}, 32'd0);
        chk("rst_mem_v", {31'd0, bus.mem_v_o}, 32'd0);
        chk("rst_v_o",   {31'd0, bus.v_o},     32'd0);
        @(posedge clk); #1;
        bus.v_i = 1'b0;
        reset_n = 1'b1;
        #1;
        chk("rel_ready", {31'd0, bus.ready_o}, 32'd1);
        chk("rel_v_o",   {31'd0, bus.v_o},     32'd0);

        // Streaming reads of preloaded data
        r0 = resp_cnt;
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, AW'(i), '0, 1'b1);
        cyc(1'b0, 1'b0, '0, '0, 1'b1);
        cyc(1'b0, 1'b0, '0, '0, 1'b1);
        chk("stream_count", resp_cnt - r0, 32'd16);

        // Write then read back one cycle later
        cyc(1'b1, 1'b1, 4'd5, 8'hA5, 1'b1);
        cyc(1'b1, 1'b0, 4'd5, '0, 1'b1);
        @(posedge clk); #1;
        chk("wr_rd_v",    {31'd0, bus.v_o}, 32'd1);
        chk("wr_rd_data", {24'd0, bus.data_o}, 32'hA5);
        bus.v_i = 1'b0;
        bus.yumi_i = bus.v_o;
        @(negedge clk); #1;
        cyc(1'b1, 1'b1, 4'd5, 8'd15, 1'b0);

        // Backpressure: two reads fill the credits, a third stalls
        cyc(1'b1, 1'b0, 4'd1, '0, 1'b0);
        cyc(1'b1, 1'b0, 4'd2, '0, 1'b0);
        cyc(1'b1, 1'b0, 4'd3, '0, 1'b0);
        chk("bp_full", {31'd0, bus.ready_o}, 32'd0);
        cyc(1'b0, 1'b0, '0, '0, 1'b1);
        cyc(1'b0, 1'b0, '0, '0, 1'b1);
        chk("bp_ready", {31'd0, bus.ready_o}, 32'd1);

        // Reset pulsed while a read is in flight
        cyc(1'b1, 1'b0, 4'd7, '0, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        exp_q.delete();
        bus.v_i = 1'b1;
        bus.yumi_i = 1'b0;
        #2;
        chk("midrst_v_o",   {31'd0, bus.v_o},     32'd0);
        chk("midrst_ready", {31'd0, bus.ready_o}, 32'd0);
        chk("midrst_mem_v", {31'd0, bus.mem_v_o}, 32'd0);
        @(posedge clk); #1;
        bus.v_i = 1'b0;
        reset_n = 1'b1;
        #1;
        chk("midrst_rel_ready", {31'd0, bus.ready_o}, 32'd1);
        chk("midrst_rel_v_o",   {31'd0, bus.v_o},     32'd0);
        cyc(1'b0, 1'b0, '0, '0, 1'b1);
        cyc(1'b0, 1'b0, '0, '0, 1'b1);

        // Random mixed traffic
        for (int i = 0; i < 10000; i++) begin
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                AW'($urandom_range(0, E - 1)), W'($urandom),
                $urandom_range(0, 9) < 6);
        end
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, '0, '0, 1'b1);
        chk("drain_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
